// File: rtl/servant_irq_tracer.sv
// servant_irq_tracer: interrupt-latency statistics and fetch-address trace monitor.
// Define SERVANT_IRQ_TRACER_TRACE_EN to build the circular trace buffer.
module servant_irq_tracer #(
    parameter int          NIRQ  = 1,
    parameter logic [31:0] MTVEC = 32'h0000_0000,
    parameter int          LAT_W = 16,
    parameter int          CNT_W = 16,
    parameter int          DEPTH = 16,
    localparam int         SW    = NIRQ > 1 ? $clog2(NIRQ) : 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [31:0]      pc_adr,
    input  logic             pc_vld,
    input  logic [NIRQ-1:0]  irq,
    input  logic [NIRQ-1:0]  irq_mask,
    input  logic             mret,
    input  logic             clr,
    output logic             busy,
    output logic [SW-1:0]    irq_src,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_max,
    output logic [CNT_W-1:0] irq_cnt,
    output logic             lat_sat,
    input  logic             tr_rd,
    output logic [31:0]      tr_data,
    output logic             tr_empty,
    output logic             tr_ovf
);
    typedef enum logic [1:0] {IDLE, PEND, HANDLER} state_t;
    state_t state;
    logic [NIRQ-1:0]  irq_q;
    logic [NIRQ-1:0]  edge_v;
    logic [SW-1:0]    src_n;
    logic [LAT_W-1:0] cnt;
    logic             hit;
    assign edge_v = irq & irq_mask & ~irq_q;
    assign hit    = pc_vld && pc_adr == MTVEC;
    // Descending scan leaves the lowest set index as the winner.
    always_comb begin
        src_n = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (edge_v[i]) src_n = SW'(i);
    end
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            irq_q    <= '0;
            irq_src  <= '0;
            cnt      <= '0;
            lat_last <= '0;
            lat_max  <= '0;
            irq_cnt  <= '0;
            lat_sat  <= 1'b0;
        end else begin
            irq_q <= irq;
            case (state)
                IDLE: if (|edge_v) begin
                    state   <= PEND;
                    busy    <= 1'b1;
                    irq_src <= src_n;
                    cnt     <= LAT_W'(1);
                end
                PEND: if (hit) begin
                    state    <= HANDLER;
                    lat_last <= cnt;
                    lat_max  <= cnt > lat_max ? cnt : lat_max;
                    irq_cnt  <= &irq_cnt ? irq_cnt : irq_cnt + 1'b1;
                end else if (mret) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (&cnt) begin
                    lat_sat <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HANDLER: if (mret) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (clr) begin
                lat_last <= '0;
                lat_max  <= '0;
                irq_cnt  <= '0;
                lat_sat  <= 1'b0;
            end
        end
    end
`ifdef SERVANT_IRQ_TRACER_TRACE_EN
    localparam int AW = $clog2(DEPTH);
    logic [31:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        full, pop, drop;
    assign tr_empty = wp == rp;
    assign full     = (wp - rp) == (AW + 1)'(DEPTH);
    assign pop      = tr_rd && !tr_empty;
    assign drop     = pc_vld && full && !pop;
    assign tr_data  = tr_empty ? 32'h0 : mem[rp[AW-1:0]];
    always_ff @(posedge wb_clk)
        if (pc_vld) mem[wp[AW-1:0]] <= pc_adr;
    // A push into a full buffer discards the oldest entry by advancing rp.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wp     <= '0;
            rp     <= '0;
            tr_ovf <= 1'b0;
        end else begin
            if (pc_vld) wp <= wp + 1'b1;
            if (pop || drop) rp <= rp + 1'b1;
            if (drop) tr_ovf <= 1'b1;
        end
    end
`else
    logic unused;
    assign unused   = tr_rd | DEPTH[0];
    assign tr_data  = 32'h0;
    assign tr_empty = 1'b1;
    assign tr_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_servant_irq_tracer.sv
// tb_servant_irq_tracer: directed checks of latency stats, priority, saturation and trace.
module tb_servant_irq_tracer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_irq = 0, a_mask = 1, a_vld = 0, a_mret = 0, a_clr = 0, a_rd = 0;
    logic [31:0] a_adr = 0;
    logic        a_busy, a_sat, a_empty, a_ovf;
    logic [0:0]  a_src;
    logic [15:0] a_last, a_max, a_cnt;
    logic [31:0] a_data;

    logic [3:0]  b_irq = 0, b_mask = 0;
    logic        b_vld = 0, b_mret = 0, b_clr = 0, b_rd = 0;
    logic [31:0] b_adr = 0;
    logic        b_busy, b_sat, b_empty, b_ovf;
    logic [1:0]  b_src;
    logic [3:0]  b_last, b_max;
    logic [15:0] b_cnt;
    logic [31:0] b_data;

    servant_irq_tracer u_a (
        .wb_clk(clk), .wb_rst_n(rst_n), .pc_adr(a_adr), .pc_vld(a_vld), .irq(a_irq),
        .irq_mask(a_mask), .mret(a_mret), .clr(a_clr), .busy(a_busy), .irq_src(a_src),
        .lat_last(a_last), .lat_max(a_max), .irq_cnt(a_cnt), .lat_sat(a_sat),
        .tr_rd(a_rd), .tr_data(a_data), .tr_empty(a_empty), .tr_ovf(a_ovf));

    servant_irq_tracer #(.NIRQ(4), .MTVEC(32'h80), .LAT_W(4), .DEPTH(4)) u_b (
        .wb_clk(clk), .wb_rst_n(rst_n), .pc_adr(b_adr), .pc_vld(b_vld), .irq(b_irq),
        .irq_mask(b_mask), .mret(b_mret), .clr(b_clr), .busy(b_busy), .irq_src(b_src),
        .lat_last(b_last), .lat_max(b_max), .irq_cnt(b_cnt), .lat_sat(b_sat),
        .tr_rd(b_rd), .tr_data(b_data), .tr_empty(b_empty), .tr_ovf(b_ovf));

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic trap_a(input int lat);
        a_irq = 1;
        tick;
        a_irq = 0;
        repeat (lat - 1) tick;
        a_vld = 1;
        a_adr = 32'h0;
        tick;
        a_vld = 0;
        a_mret = 1;
        tick;
        a_mret = 0;
    endtask

    initial begin
        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_src", a_src, 0);
        chk("rst_last", a_last, 0);
        chk("rst_max", a_max, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_data", a_data, 0);
        chk("rst_ovf", a_ovf, 0);
        tick;
        rst_n = 1;
        tick;

        // basic latency of 5
        a_irq = 1;
        tick;
        chk("basic_busy_rise", a_busy, 1);
        repeat (4) tick;
        a_vld = 1;
        tick;
        a_vld = 0;
        a_irq = 0;
        chk("basic_last", a_last, 5);
        chk("basic_max", a_max, 5);
        chk("basic_cnt", a_cnt, 1);
        chk("basic_busy_hold", a_busy, 1);
        a_mret = 1;
        tick;
        a_mret = 0;
        chk("basic_busy_fall", a_busy, 0);

        a_clr = 1;
        tick;
        a_clr = 0;
        chk("clr_last", a_last, 0);
        chk("clr_max", a_max, 0);
        chk("clr_cnt", a_cnt, 0);

        // max tracking then spurious trap
        trap_a(7);
        trap_a(3);
        chk("max_last", a_last, 3);
        chk("max_max", a_max, 7);
        chk("max_cnt", a_cnt, 2);
        a_irq = 1;
        tick;
        a_irq = 0;
        tick;
        tick;
        chk("spur_busy", a_busy, 1);
        a_mret = 1;
        tick;
        a_mret = 0;
        chk("spur_idle", a_busy, 0);
        chk("spur_last", a_last, 3);
        chk("spur_max", a_max, 7);
        chk("spur_cnt", a_cnt, 2);

        // clear wins over a same-cycle capture
        a_irq = 1;
        tick;
        a_irq = 0;
        a_vld = 1;
        a_clr = 1;
        tick;
        a_vld = 0;
        a_clr = 0;
        chk("clrpri_last", a_last, 0);
        chk("clrpri_cnt", a_cnt, 0);
        chk("clrpri_busy", a_busy, 1);
        a_mret = 1;
        tick;
        a_mret = 0;

        // priority and mask
        b_mask = 4'b1100;
        b_irq = 4'b1111;
        tick;
        chk("prio_src", b_src, 2);
        chk("prio_busy", b_busy, 1);
        b_mret = 1;
        tick;
        b_mret = 0;
        b_irq = 0;
        tick;
        b_irq = 4'b0011;
        tick;
        tick;
        chk("mask_busy", b_busy, 0);
        b_irq = 0;

        // latency saturation with LAT_W=4
        b_irq = 4'b1000;
        tick;
        b_irq = 0;
        repeat (20) tick;
        chk("sat_flag", b_sat, 1);
        chk("sat_src", b_src, 3);
        b_vld = 1;
        b_adr = 32'h80;
        tick;
        b_vld = 0;
        chk("sat_last", b_last, 15);
        chk("sat_max", b_max, 15);
        chk("sat_cnt", b_cnt, 1);
        b_mret = 1;
        tick;
        b_mret = 0;
        b_clr = 1;
        tick;
        b_clr = 0;
        chk("satclr_last", b_last, 0);
        chk("satclr_max", b_max, 0);
        chk("satclr_cnt", b_cnt, 0);
        chk("satclr_sat", b_sat, 0);

        // edges outside IDLE are not queued
        b_mask = 4'b1111;
        b_irq = 4'b0001;
        tick;
        chk("noq_src", b_src, 0);
        b_irq = 4'b0011;
        tick;
        b_irq = 0;
        b_mret = 1;
        tick;
        b_mret = 0;
        chk("noq_idle", b_busy, 0);
        tick;
        chk("noq_stay", b_busy, 0);

        rst_n = 0;
        #1;
        rst_n = 1;
        tick;

        // trace wrap
        for (int k = 0; k < 6; k++) begin
            b_vld = 1;
            b_adr = 32'h100 + 32'(4 * k);
            tick;
        end
        b_vld = 0;
`ifdef SERVANT_IRQ_TRACER_TRACE_EN
        chk("wrap_ovf", b_ovf, 1);
        chk("wrap_empty", b_empty, 0);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_data", b_data, 32'h108 + 32'(4 * k));
            b_rd = 1;
            tick;
        end
        b_rd = 0;
        chk("wrap_drained", b_empty, 1);
        chk("wrap_zero", b_data, 0);
        b_rd = 1;
        tick;
        b_rd = 0;
        chk("rd_empty_ignored", b_empty, 1);

        rst_n = 0;
        #1;
        rst_n = 1;
        tick;
        for (int k = 0; k < 4; k++) begin
            b_vld = 1;
            b_adr = 32'h200 + 32'(4 * k);
            tick;
        end
        chk("full_ovf", b_ovf, 0);
        b_adr = 32'h210;
        b_rd = 1;
        tick;
        b_vld = 0;
        b_rd = 0;
        chk("pp_ovf", b_ovf, 0);
        for (int k = 0; k < 4; k++) begin
            chk("pp_data", b_data, 32'h204 + 32'(4 * k));
            b_rd = 1;
            tick;
        end
        b_rd = 0;
        chk("pp_empty", b_empty, 1);
`else
        chk("off_empty", b_empty, 1);
        chk("off_data", b_data, 0);
        chk("off_ovf", b_ovf, 0);
`endif

        // asynchronous reset mid-PEND
        trap_a(4);
        a_irq = 1;
        tick;
        a_irq = 0;
        tick;
        chk("pre_rst_busy", a_busy, 1);
        chk("pre_rst_last", a_last, 4);
        rst_n = 0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_last", a_last, 0);
        chk("arst_max", a_max, 0);
        chk("arst_cnt", a_cnt, 0);
        chk("arst_empty", b_empty, 1);
        chk("arst_ovf", b_ovf, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
